// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory ports of the memory arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic [31:0] if_data_o;
  logic        if_valid_o;

  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_rdata_o;
  logic        d_done_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_data_i;
  logic        mem_valid_i;
  logic        mem_ready_i;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_data_o, if_valid_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i,
    output d_rdata_o, d_done_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_data_o, mem_sel_o,
    input  mem_data_i, mem_valid_i, mem_ready_i
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_data_o, if_valid_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i,
    input  d_rdata_o, d_done_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_data_o, mem_sel_o,
    output mem_data_i, mem_valid_i, mem_ready_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) round-robin arbiter onto a single memory port,
// one outstanding transaction at a time.
module mem_arbiter (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } mem_cmd_t;

  state_t      state, state_nxt;
  logic        grant, grant_d;
  logic        last_data;
  logic        gnt_data;
  logic        drop;
  mem_cmd_t    cmd, cmd_q;
  logic [31:0] if_data_q, d_rdata_q;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: if (bus.mem_ready_i && (bus.if_req_i || bus.d_req_i)) begin
        grant     = 1'b1;
        // data wins a tie only when fetch was served last
        grant_d   = bus.d_req_i && (!bus.if_req_i || !last_data);
        state_nxt = REQ;
      end
      REQ:     state_nxt = cmd_q.we ? RESP : WAIT;
      WAIT:    if (bus.mem_valid_i) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if (grant_d)
      cmd = '{we: bus.d_we_i, addr: bus.d_addr_i, data: bus.d_wdata_i, sel: bus.d_sel_i};
    else
      cmd = '{we: 1'b0, addr: bus.if_addr_i, data: 32'h0, sel: 4'hf};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_data <= 1'b0;
      gnt_data  <= 1'b0;
      drop      <= 1'b0;
      cmd_q     <= '0;
      if_data_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt_data  <= grant_d;
        last_data <= grant_d;
        cmd_q     <= cmd;
      end
      if (state == WAIT && bus.mem_valid_i) begin
        if (gnt_data) d_rdata_q <= bus.mem_data_i;
        else          if_data_q <= bus.mem_data_i;
      end
      // a flushed fetch still completes on the bus but its pulse is swallowed
      if (state == RESP)
        drop <= 1'b0;
      else if ((state == REQ || state == WAIT) && !gnt_data && bus.if_flush_i)
        drop <= 1'b1;
    end
  end

  assign bus.mem_req_o  = (state == REQ);
  assign bus.mem_we_o   = cmd_q.we;
  assign bus.mem_addr_o = cmd_q.addr;
  assign bus.mem_data_o = cmd_q.data;
  assign bus.mem_sel_o  = cmd_q.sel;
  assign bus.if_data_o  = if_data_q;
  assign bus.d_rdata_o  = d_rdata_q;
  assign bus.if_valid_o = (state == RESP) && !gnt_data && !drop && !bus.if_flush_i;
  assign bus.d_done_o   = (state == RESP) && gnt_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte-lane memory model.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   mem_lat;
  int   cnt;
  bit   mem_init;
  logic [11:0] rd_idx;
  logic [31:0] mem [0:4095];

  mem_arbiter_if bus();

  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: reads answer mem_lat cycles after the request cycle, writes honour sel
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem[12'h040] = 32'h00000013;
      mem[12'h041] = 32'h00500093;
      mem[12'h801] = 32'h11223344;
      mem_init = 1'b1;
      cnt = 0;
    end
    bus.mem_valid_i = 1'b0;
    bus.mem_data_i  = 32'hBAD0BAD0;
    if (bus.mem_req_o) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_sel_o[b]) mem[bus.mem_addr_o[13:2]][8*b +: 8] = bus.mem_data_o[8*b +: 8];
      end else begin
        cnt    = mem_lat;
        rd_idx = bus.mem_addr_o[13:2];
      end
    end else if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = mem[rd_idx];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.if_req_i = 0; bus.if_addr_i = 0; bus.if_flush_i = 0;
    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = 0; bus.d_wdata_i = 0; bus.d_sel_i = 0;
    bus.mem_ready_i = 1'b1;
    mem_lat = 1;
    repeat (3) tick;
    n_cmp++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, bus.mem_sel_o,
         bus.if_valid_o, bus.if_data_o, bus.d_done_o, bus.d_rdata_o} !== 136'h0) begin
      n_bad++; $display("FAIL reset_outputs: got nonzero outputs want all 0");
    end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_fetch;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    tick;
    n_cmp++;
    if (bus.mem_req_o !== 1'b1) begin n_bad++; $display("FAIL fetch_req: got %b want 1", bus.mem_req_o); end
    n_cmp++;
    if ({bus.mem_we_o, bus.mem_sel_o, bus.mem_addr_o, bus.mem_data_o} !== {1'b0, 4'hf, 32'h100, 32'h0}) begin
      n_bad++; $display("FAIL fetch_cmd: got we=%b sel=%h addr=%h data=%h want 0 f 100 0",
                        bus.mem_we_o, bus.mem_sel_o, bus.mem_addr_o, bus.mem_data_o);
    end
    tick;
    n_cmp++;
    if ({bus.mem_req_o, bus.if_valid_o, bus.mem_addr_o} !== {2'b00, 32'h100}) begin
      n_bad++; $display("FAIL fetch_wait: got req=%b vld=%b addr=%h want 0 0 100",
                        bus.mem_req_o, bus.if_valid_o, bus.mem_addr_o);
    end
    tick;
    n_cmp++;
    if (bus.if_valid_o !== 1'b1) begin n_bad++; $display("FAIL fetch_valid: got %b want 1", bus.if_valid_o); end
    n_cmp++;
    if (bus.if_data_o !== 32'h00000013) begin n_bad++; $display("FAIL fetch_data: got %h want 00000013", bus.if_data_o); end
    bus.if_req_i = 1'b0;
    tick;
    n_cmp++;
    if ({bus.if_valid_o, bus.if_data_o} !== {1'b0, 32'h13}) begin
      n_bad++; $display("FAIL fetch_hold: got vld=%b data=%h want 0 00000013", bus.if_valid_o, bus.if_data_o);
    end
  endtask

  task automatic test_store;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 32'h2004;
    bus.d_wdata_i = 32'hAABBCCDD; bus.d_sel_i = 4'b0011;
    tick;
    n_cmp++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_sel_o} !== {2'b11, 4'b0011}) begin
      n_bad++; $display("FAIL store_req: got req=%b we=%b sel=%b want 1 1 0011",
                        bus.mem_req_o, bus.mem_we_o, bus.mem_sel_o);
    end
    n_cmp++;
    if ({bus.mem_addr_o, bus.mem_data_o} !== {32'h2004, 32'hAABBCCDD}) begin
      n_bad++; $display("FAIL store_bus: got addr=%h data=%h want 00002004 aabbccdd", bus.mem_addr_o, bus.mem_data_o);
    end
    tick;
    n_cmp++;
    if ({bus.d_done_o, bus.mem_req_o} !== 2'b10) begin
      n_bad++; $display("FAIL store_done: got done=%b req=%b want 1 0", bus.d_done_o, bus.mem_req_o);
    end
    n_cmp++;
    if (mem[12'h801] !== 32'h1122CCDD) begin n_bad++; $display("FAIL store_bytes: got %h want 1122ccdd", mem[12'h801]); end
    bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
    tick;
    n_cmp++;
    if (bus.d_done_o !== 1'b0) begin n_bad++; $display("FAIL store_pulse: got %b want 0", bus.d_done_o); end
  endtask

  task automatic test_data_read_flush;
    // a flush aimed at the fetch side must not touch a data read
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h2004; bus.d_sel_i = 4'hf;
    bus.if_flush_i = 1'b1;
    repeat (3) tick;
    n_cmp++;
    if ({bus.d_done_o, bus.d_rdata_o} !== {1'b1, 32'h1122CCDD}) begin
      n_bad++; $display("FAIL dread_done: got done=%b data=%h want 1 1122ccdd", bus.d_done_o, bus.d_rdata_o);
    end
    bus.d_req_i = 1'b0; bus.if_flush_i = 1'b0;
    tick;
  endtask

  task automatic test_flush;
    int seen_vld;
    int seen_req;
    mem_lat = 4;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h104;
    tick;
    tick;
    bus.if_flush_i = 1'b1; bus.if_req_i = 1'b0;
    tick;
    bus.if_flush_i = 1'b0;
    seen_vld = 0; seen_req = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.if_valid_o) seen_vld++;
      if (bus.mem_req_o) seen_req++;
      tick;
    end
    n_cmp++;
    if (seen_vld != 0) begin n_bad++; $display("FAIL flush_suppress: got %0d pulses want 0", seen_vld); end
    n_cmp++;
    if (seen_req != 0) begin n_bad++; $display("FAIL flush_reissue: got %0d requests want 0", seen_req); end
    n_cmp++;
    if (bus.if_data_o !== 32'h00500093) begin n_bad++; $display("FAIL flush_capture: got %h want 00500093", bus.if_data_o); end
    mem_lat = 1;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    repeat (3) tick;
    n_cmp++;
    if ({bus.if_valid_o, bus.if_data_o} !== {1'b1, 32'h13}) begin
      n_bad++; $display("FAIL flush_next: got vld=%b data=%h want 1 00000013", bus.if_valid_o, bus.if_data_o);
    end
    bus.if_req_i = 1'b0;
    tick;
  endtask

  task automatic test_flush_resp;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    repeat (3) tick;
    n_cmp++;
    if (bus.if_valid_o !== 1'b1) begin n_bad++; $display("FAIL fresp_pre: got %b want 1", bus.if_valid_o); end
    bus.if_flush_i = 1'b1;
    #1;
    n_cmp++;
    if (bus.if_valid_o !== 1'b0) begin n_bad++; $display("FAIL fresp_kill: got %b want 0", bus.if_valid_o); end
    bus.if_req_i = 1'b0;
    tick;
    bus.if_flush_i = 1'b0;
    tick;
  endtask

  task automatic test_stall;
    int k;
    bus.mem_ready_i = 1'b0;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h2004; bus.d_sel_i = 4'hf;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if (bus.mem_req_o !== 1'b0) begin n_bad++; $display("FAIL stall_hold%0d: got %b want 0", i, bus.mem_req_o); end
    end
    bus.mem_ready_i = 1'b1;
    tick;
    n_cmp++;
    if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h2004}) begin
      n_bad++; $display("FAIL stall_release: got req=%b addr=%h want 1 00002004", bus.mem_req_o, bus.mem_addr_o);
    end
    // dropping ready mid-transaction must not stall the issued read
    bus.mem_ready_i = 1'b0;
    for (k = 0; k < 10 && !bus.d_done_o; k++) tick;
    n_cmp++;
    if (bus.d_done_o !== 1'b1) begin n_bad++; $display("FAIL stall_complete: got %b want 1", bus.d_done_o); end
    bus.d_req_i = 1'b0; bus.if_req_i = 1'b0; bus.mem_ready_i = 1'b1;
    tick;
  endtask

  task automatic test_mid_reset;
    int pulses;
    mem_lat = 5;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    tick;
    tick;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, bus.mem_sel_o,
         bus.if_valid_o, bus.if_data_o, bus.d_done_o, bus.d_rdata_o} !== 136'h0) begin
      n_bad++; $display("FAIL mreset_async: got addr=%h sel=%h ifd=%h dd=%h want all 0",
                        bus.mem_addr_o, bus.mem_sel_o, bus.if_data_o, bus.d_rdata_o);
    end
    tick;
    rst = 1'b1; bus.if_req_i = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (bus.if_valid_o || bus.d_done_o || bus.mem_req_o) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin n_bad++; $display("FAIL mreset_quiet: got %0d activity cycles want 0", pulses); end
    mem_lat = 1;
  endtask

  task automatic test_back_to_back;
    logic [3:0] order;
    int gcyc [4];
    int ngr;
    ngr = 0; order = 4'b0;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h2004; bus.d_sel_i = 4'hf;
    for (int c = 0; c < 40 && ngr < 4; c++) begin
      tick;
      if (bus.mem_req_o) begin
        order[ngr] = (bus.mem_addr_o == 32'h2004);
        gcyc[ngr]  = c;
        ngr++;
      end
    end
    n_cmp++;
    if (ngr != 4) begin n_bad++; $display("FAIL rr_count: got %0d grants want 4", ngr); end
    n_cmp++;
    if (order !== 4'b0101) begin n_bad++; $display("FAIL rr_order: got %b want 0101 (bit0 first, 1=data)", order); end
    n_cmp++;
    if (ngr == 4 && gcyc[3] - gcyc[0] != 12) begin
      n_bad++; $display("FAIL rr_spacing: got %0d cycles want 12", gcyc[3] - gcyc[0]);
    end
    repeat (3) tick;
    bus.if_req_i = 1'b0; bus.d_req_i = 1'b0;
    n_cmp++;
    if ({bus.d_rdata_o, bus.if_data_o} !== {32'h1122CCDD, 32'h13}) begin
      n_bad++; $display("FAIL rr_data: got d=%h if=%h want 1122ccdd 00000013", bus.d_rdata_o, bus.if_data_o);
    end
    repeat (4) tick;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset;
    test_fetch;
    test_store;
    test_data_read_flush;
    test_flush;
    test_flush_resp;
    test_stall;
    test_mid_reset;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
